// File: rtl/peripheral_ahb3_verilog_pkg.sv
// Shared AHB3-Lite constants, SRAM slave state encoding and byte-lane decode.
package peripheral_ahb3_verilog_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;
    localparam logic [2:0] HSIZE_B128  = 3'b100;
    localparam logic [2:0] HSIZE_B256  = 3'b101;
    localparam logic [2:0] HSIZE_B512  = 3'b110;
    localparam logic [2:0] HSIZE_B1024 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDWAIT,
        ERR1,
        ERR2
    } sram_state_t;

    // Byte lanes covered by a transfer of 2^hsize bytes starting at lane 'offset' (up to 16 lanes).
    function automatic logic [15:0] gen_be(input logic [2:0] hsize, input logic [3:0] offset);
        logic [15:0] lanes;
        unique case (hsize)
            HSIZE_BYTE:  lanes = 16'h0001;
            HSIZE_HWORD: lanes = 16'h0003;
            HSIZE_WORD:  lanes = 16'h000F;
            HSIZE_DWORD: lanes = 16'h00FF;
            default:     lanes = 16'hFFFF;
        endcase
        return lanes << offset;
    endfunction

endpackage

// File: rtl/mpsoc_ahb3_sram_fwd_if.sv
// AHB3-Lite slave-port signal bundle for the SRAM slave.
interface mpsoc_ahb3_sram_fwd_if #(
    parameter int unsigned PLEN = 32,
    parameter int unsigned XLEN = 32
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADYOUT;
    logic            HREADY;
    logic            HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/mpsoc_ram_1r1w.sv
// Generic synchronous RAM: one byte-enabled write port, one registered read port (read-first).
module mpsoc_ram_1r1w #(
    parameter int unsigned ABITS      = 8,
    parameter int unsigned DBITS      = 32,
    parameter string       TECHNOLOGY = "GENERIC"
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [ABITS-1:0]   i_waddr,
    input  logic [DBITS/8-1:0] i_be,
    input  logic [DBITS-1:0]   i_wdata,
    input  logic               i_re,
    input  logic [ABITS-1:0]   i_raddr,
    output logic [DBITS-1:0]   o_rdata
);
    // Only the generic behavioural model exists today; vendor macros would key off TECHNOLOGY.
    localparam bit unused_tech = (TECHNOLOGY == "GENERIC");

    logic [DBITS-1:0] r_mem [2**ABITS];
    logic [DBITS-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < DBITS/8; b++) begin
                if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/mpsoc_ahb3_sram_fwd.sv
// AHB3-Lite SRAM slave with write-to-read forwarding, optional read wait states
// and two-cycle ERROR response for out-of-range or oversize accesses.
module mpsoc_ahb3_sram_fwd
    import peripheral_ahb3_verilog_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 256,
    parameter int unsigned PLEN         = 32,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned READ_WAIT    = 0,
    parameter bit          ERROR_ON_OOR = 1'b1,
    parameter string       TECHNOLOGY   = "GENERIC"
) (
    input logic                  HRESETn,
    input logic                  HCLK,
    mpsoc_ahb3_sram_fwd_if.slave bus
);
    localparam int unsigned BYTES     = XLEN / 8;
    localparam int unsigned LSB       = $clog2(BYTES);
    localparam int unsigned ABITS     = $clog2(MEM_DEPTH);
    localparam int unsigned CW        = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
    localparam logic [2:0]  SZMAX     = 3'(LSB);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(BYTES);

    sram_state_t      r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_hreadyout, w_hreadyout_nxt;
    logic             r_hresp, w_hresp_nxt;
    logic [ABITS-1:0] r_wr_idx, w_idx;
    logic [BYTES-1:0] r_wr_be, w_be, r_fwd_be;
    logic [XLEN-1:0]  r_fwd_data, r_hold, r_hrdata;
    logic [XLEN-1:0]  w_ram_dout, w_rd_src, w_rd_data;
    logic [PLEN-1:0]  w_haddr;
    logic [2:0]       w_size_eff;
    logic [3:0]       w_offset;
    logic             w_active, w_accept, w_oversize, w_oor, w_fault, w_fwd_hit;
    logic             w_ram_we, w_ram_re;
    logic             w_unused;

    // Address-phase decode
    assign w_haddr    = bus.HADDR;
    assign w_active   = r_state inside {IDLE, WR, RD, ERR2};
    assign w_accept   = w_active & bus.HSEL & bus.HREADY
                      & ((bus.HTRANS == HTRANS_NONSEQ) | (bus.HTRANS == HTRANS_SEQ));
    assign w_idx      = w_haddr[LSB +: ABITS];
    assign w_oversize = bus.HSIZE > SZMAX;
    assign w_oor      = 64'(w_haddr) >= MEM_BYTES;
    assign w_fault    = ERROR_ON_OOR & (w_oor | w_oversize);
    assign w_size_eff = w_oversize ? SZMAX : bus.HSIZE;
    assign w_offset   = w_haddr[3:0] & 4'(BYTES - 1);
    assign w_be       = BYTES'(gen_be(w_size_eff, w_offset));
    assign w_fwd_hit  = (r_state == WR) && (w_idx == r_wr_idx);
    assign w_unused   = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};

    // Next state and next registered handshake outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hreadyout_nxt = 1'b1;
        w_hresp_nxt     = HRESP_OKAY;
        unique case (r_state)
            RDWAIT: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) w_state_nxt = RD;
            end
            ERR1: w_state_nxt = ERR2;
            default: begin
                w_state_nxt = IDLE;
                if (w_accept) begin
                    if (w_fault) begin
                        w_state_nxt = ERR1;
                    end else if (bus.HWRITE) begin
                        w_state_nxt = WR;
                    end else if (READ_WAIT == 0) begin
                        w_state_nxt = RD;
                    end else begin
                        w_state_nxt = RDWAIT;
                        w_cnt_nxt   = CW'(READ_WAIT);
                    end
                end
            end
        endcase
        if (w_state_nxt inside {RDWAIT, ERR1}) w_hreadyout_nxt = 1'b0;
        if (w_state_nxt inside {ERR1, ERR2})   w_hresp_nxt     = HRESP_ERROR;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_hresp     <= w_hresp_nxt;
        end
    end

    // Pending write, forwarding capture, wait-state hold and HRDATA history
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_idx   <= '0;
            r_wr_be    <= '0;
            r_fwd_be   <= '0;
            r_fwd_data <= '0;
            r_hold     <= '0;
            r_hrdata   <= '0;
        end else begin
            if (w_accept && !w_fault) begin
                if (bus.HWRITE) begin
                    r_wr_idx <= w_idx;
                    r_wr_be  <= w_be;
                end else begin
                    r_fwd_be   <= w_fwd_hit ? r_wr_be : '0;
                    r_fwd_data <= bus.HWDATA;
                end
            end
            if (r_state == RDWAIT) r_hold   <= w_ram_dout;
            if (r_state == RD)     r_hrdata <= w_rd_data;
        end
    end

    assign w_ram_we = (r_state == WR);
    assign w_ram_re = w_accept & ~w_fault & ~bus.HWRITE;

    mpsoc_ram_1r1w #(
        .ABITS      (ABITS),
        .DBITS      (XLEN),
        .TECHNOLOGY (TECHNOLOGY)
    ) u_ram (
        .clk     (HCLK),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_idx),
        .i_be    (r_wr_be),
        .i_wdata (bus.HWDATA),
        .i_re    (w_ram_re),
        .i_raddr (w_idx),
        .o_rdata (w_ram_dout)
    );

    // RAM reads the old word when a same-index write commits on the same edge; overlay it here.
    assign w_rd_src = (READ_WAIT == 0) ? w_ram_dout : r_hold;

    always_comb begin
        w_rd_data = w_rd_src;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (r_fwd_be[b]) w_rd_data[b*8 +: 8] = r_fwd_data[b*8 +: 8];
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = (r_state == RD) ? w_rd_data : r_hrdata;
endmodule

// File: tb/tb_mpsoc_ahb3_sram_fwd.sv
// Directed bench: three slave instances (default, READ_WAIT=2, ERROR_ON_OOR=0) on a shared master.
module tb_mpsoc_ahb3_sram_fwd;
    import peripheral_ahb3_verilog_pkg::*;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    int          b_dut    = 0;
    logic        b_hsel   = 1'b0;
    logic [31:0] b_haddr  = 32'h0;
    logic        b_hwrite = 1'b0;
    logic [2:0]  b_hsize  = HSIZE_WORD;
    logic [1:0]  b_htrans = HTRANS_IDLE;
    logic [31:0] b_hwdata = 32'h0;

    logic        o_ready [3];
    logic        o_resp  [3];
    logic [31:0] o_rdata [3];
    logic        m_hready, m_hresp;
    logic [31:0] m_hrdata;

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mpsoc_ahb3_sram_fwd_if #(.PLEN(32), .XLEN(32)) bus_if ();
        assign bus_if.HSEL      = b_hsel && (b_dut == g);
        assign bus_if.HADDR     = b_haddr;
        assign bus_if.HWDATA    = b_hwdata;
        assign bus_if.HWRITE    = b_hwrite;
        assign bus_if.HSIZE     = b_hsize;
        assign bus_if.HBURST    = 3'b000;
        assign bus_if.HPROT     = 4'b0011;
        assign bus_if.HTRANS    = b_htrans;
        assign bus_if.HMASTLOCK = 1'b0;
        assign bus_if.HREADY    = bus_if.HREADYOUT;

        mpsoc_ahb3_sram_fwd #(
            .MEM_DEPTH    (256),
            .PLEN         (32),
            .XLEN         (32),
            .READ_WAIT    ((g == 1) ? 2 : 0),
            .ERROR_ON_OOR ((g == 2) ? 1'b0 : 1'b1),
            .TECHNOLOGY   ("GENERIC")
        ) u_dut (
            .HRESETn (HRESETn),
            .HCLK    (HCLK),
            .bus     (bus_if)
        );

        assign o_ready[g] = bus_if.HREADYOUT;
        assign o_resp[g]  = bus_if.HRESP;
        assign o_rdata[g] = bus_if.HRDATA;
    end

    assign m_hready = o_ready[b_dut];
    assign m_hresp  = o_resp[b_dut];
    assign m_hrdata = o_rdata[b_dut];

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_addr(input logic [31:0] addr, input logic wr, input logic [2:0] size);
        b_hsel   = 1'b1;
        b_htrans = HTRANS_NONSEQ;
        b_haddr  = addr;
        b_hwrite = wr;
        b_hsize  = size;
    endtask

    task automatic drive_idle();
        b_hsel   = 1'b0;
        b_htrans = HTRANS_IDLE;
        b_hwrite = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        drive_addr(addr, 1'b1, HSIZE_WORD);
        tick();
        b_hwdata = data;
        drive_idle();
        tick();
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output int waits);
        drive_addr(addr, 1'b0, HSIZE_WORD);
        tick();
        drive_idle();
        waits = 0;
        while (m_hready !== 1'b1 && waits < 20) begin
            tick();
            waits++;
        end
        data = m_hrdata;
        tick();
    endtask

    task automatic test_reset();
        b_dut = 0;
        checks++; if (m_hready !== 1'b1) begin failures++; $display("FAIL rst_hready got=%0b exp=1", m_hready); end
        checks++; if (m_hresp !== 1'b0) begin failures++; $display("FAIL rst_hresp got=%0b exp=0", m_hresp); end
        checks++; if (m_hrdata !== 32'h0) begin failures++; $display("FAIL rst_hrdata got=%h exp=00000000", m_hrdata); end
    endtask

    task automatic test_write_read();
        b_dut = 0;
        drive_addr(32'h10, 1'b1, HSIZE_WORD);
        tick();
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin failures++; $display("FAIL wr_phase got rdy=%0b resp=%0b exp rdy=1 resp=0", m_hready, m_hresp); end
        b_hwdata = 32'hDEADBEEF;
        drive_addr(32'h10, 1'b0, HSIZE_WORD);
        tick();
        drive_idle();
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin failures++; $display("FAIL rd_phase got rdy=%0b resp=%0b exp rdy=1 resp=0", m_hready, m_hresp); end
        checks++; if (m_hrdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_data got=%h exp=deadbeef", m_hrdata); end
        tick();
        checks++; if (m_hrdata !== 32'hDEADBEEF) begin failures++; $display("FAIL hrdata_hold got=%h exp=deadbeef", m_hrdata); end
    endtask

    task automatic test_forward();
        logic [31:0] d;
        int w;
        b_dut = 0;
        bus_write(32'h20, 32'h11223344);
        drive_addr(32'h21, 1'b1, HSIZE_BYTE);
        tick();
        b_hwdata = 32'h0000AA00;
        drive_addr(32'h20, 1'b0, HSIZE_WORD);
        tick();
        drive_idle();
        checks++; if (m_hready !== 1'b1) begin failures++; $display("FAIL fwd_stall got rdy=%0b exp=1", m_hready); end
        checks++; if (m_hrdata !== 32'h1122AA44) begin failures++; $display("FAIL fwd_byte got=%h exp=1122aa44", m_hrdata); end
        tick();
        bus_read(32'h20, d, w);
        checks++; if (d !== 32'h1122AA44 || w != 0) begin failures++; $display("FAIL byte_commit got=%h waits=%0d exp=1122aa44 waits=0", d, w); end
        // write to another word followed by read: must not forward
        drive_addr(32'h28, 1'b1, HSIZE_WORD);
        tick();
        b_hwdata = 32'hA5A5A5A5;
        drive_addr(32'h20, 1'b0, HSIZE_WORD);
        tick();
        drive_idle();
        checks++; if (m_hrdata !== 32'h1122AA44) begin failures++; $display("FAIL no_fwd got=%h exp=1122aa44", m_hrdata); end
        tick();
        bus_read(32'h28, d, w);
        checks++; if (d !== 32'hA5A5A5A5) begin failures++; $display("FAIL other_commit got=%h exp=a5a5a5a5", d); end
    endtask

    task automatic test_read_wait();
        int low;
        logic stable;
        b_dut = 1;
        bus_write(32'h4, 32'h0BADF00D);
        drive_addr(32'h4, 1'b0, HSIZE_WORD);
        tick();
        drive_idle();
        low = 0;
        stable = 1'b1;
        while (m_hready === 1'b0 && low < 10) begin
            if (m_hrdata !== 32'h0 || m_hresp !== 1'b0) stable = 1'b0;
            low++;
            tick();
        end
        checks++; if (low != 2) begin failures++; $display("FAIL wait_cycles got=%0d exp=2", low); end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL wait_stable got=%0b exp=1", stable); end
        checks++; if (m_hready !== 1'b1 || m_hrdata !== 32'h0BADF00D) begin failures++; $display("FAIL wait_data got rdy=%0b data=%h exp rdy=1 data=0badf00d", m_hready, m_hrdata); end
        tick();
        checks++; if (m_hrdata !== 32'h0BADF00D) begin failures++; $display("FAIL wait_hold got=%h exp=0badf00d", m_hrdata); end
        // forwarding combined with wait states
        drive_addr(32'h8, 1'b1, HSIZE_WORD);
        tick();
        b_hwdata = 32'h12345678;
        drive_addr(32'h8, 1'b0, HSIZE_WORD);
        tick();
        drive_idle();
        low = 0;
        stable = 1'b1;
        while (m_hready === 1'b0 && low < 10) begin
            if (m_hrdata !== 32'h0BADF00D) stable = 1'b0;
            low++;
            tick();
        end
        checks++; if (low != 2 || stable !== 1'b1) begin failures++; $display("FAIL wait_fwd_cycles got=%0d stable=%0b exp=2 stable=1", low, stable); end
        checks++; if (m_hrdata !== 32'h12345678) begin failures++; $display("FAIL wait_fwd_data got=%h exp=12345678", m_hrdata); end
        tick();
    endtask

    task automatic test_error();
        b_dut = 0;
        bus_write(32'h0, 32'h01020304);
        drive_addr(32'h400, 1'b1, HSIZE_WORD);
        tick();
        drive_idle();
        b_hwdata = 32'h99999999;
        checks++; if (m_hready !== 1'b0 || m_hresp !== 1'b1) begin failures++; $display("FAIL oor_err1 got rdy=%0b resp=%0b exp rdy=0 resp=1", m_hready, m_hresp); end
        tick();
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b1) begin failures++; $display("FAIL oor_err2 got rdy=%0b resp=%0b exp rdy=1 resp=1", m_hready, m_hresp); end
        drive_addr(32'h0, 1'b0, HSIZE_WORD);
        tick();
        drive_idle();
        checks++; if (m_hrdata !== 32'h01020304 || m_hresp !== 1'b0 || m_hready !== 1'b1) begin failures++; $display("FAIL oor_nowrite got data=%h resp=%0b rdy=%0b exp data=01020304 resp=0 rdy=1", m_hrdata, m_hresp, m_hready); end
        tick();
        drive_addr(32'hC, 1'b1, HSIZE_DWORD);
        tick();
        drive_idle();
        checks++; if (m_hready !== 1'b0 || m_hresp !== 1'b1) begin failures++; $display("FAIL size_err1 got rdy=%0b resp=%0b exp rdy=0 resp=1", m_hready, m_hresp); end
        tick();
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b1) begin failures++; $display("FAIL size_err2 got rdy=%0b resp=%0b exp rdy=1 resp=1", m_hready, m_hresp); end
        tick();
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin failures++; $display("FAIL err_recover got rdy=%0b resp=%0b exp rdy=1 resp=0", m_hready, m_hresp); end
    endtask

    task automatic test_no_error();
        logic [31:0] d;
        int w;
        b_dut = 2;
        drive_addr(32'h0, 1'b1, HSIZE_DWORD);
        tick();
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin failures++; $display("FAIL clamp_okay got rdy=%0b resp=%0b exp rdy=1 resp=0", m_hready, m_hresp); end
        b_hwdata = 32'h5A5A5A5A;
        drive_addr(32'h0, 1'b0, HSIZE_WORD);
        tick();
        drive_idle();
        checks++; if (m_hrdata !== 32'h5A5A5A5A) begin failures++; $display("FAIL clamp_data got=%h exp=5a5a5a5a", m_hrdata); end
        tick();
        drive_addr(32'h400, 1'b1, HSIZE_WORD);
        tick();
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin failures++; $display("FAIL wrap_okay got rdy=%0b resp=%0b exp rdy=1 resp=0", m_hready, m_hresp); end
        b_hwdata = 32'h77665544;
        drive_idle();
        tick();
        bus_read(32'h0, d, w);
        checks++; if (d !== 32'h77665544 || w != 0) begin failures++; $display("FAIL wrap_alias got=%h waits=%0d exp=77665544 waits=0", d, w); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int w;
        b_dut = 0;
        bus_write(32'h8, 32'h0F0F0F0F);
        bus_read(32'h8, d, w);
        checks++; if (d !== 32'h0F0F0F0F) begin failures++; $display("FAIL pre_rst_data got=%h exp=0f0f0f0f", d); end
        drive_addr(32'h8, 1'b1, HSIZE_WORD);
        tick();
        b_hwdata = 32'h00000055;
        drive_idle();
        HRESETn = 1'b0;
        #1;
        checks++; if (m_hrdata !== 32'h0 || m_hready !== 1'b1 || m_hresp !== 1'b0) begin failures++; $display("FAIL mid_rst_outputs got data=%h rdy=%0b resp=%0b exp data=0 rdy=1 resp=0", m_hrdata, m_hready, m_hresp); end
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        bus_read(32'h8, d, w);
        checks++; if (d !== 32'h0F0F0F0F) begin failures++; $display("FAIL rst_abort got=%h exp=0f0f0f0f", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        test_reset();
        test_write_read();
        test_forward();
        test_read_wait();
        test_error();
        test_no_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mpsoc_ahb3_sram_fwd.md
Name: mpsoc_ahb3_sram_fwd

Overview:
- Parametrised AHB3-Lite single-slave SRAM; next generation of the team's AHB3 SRAM slave.
- Write-to-read forwarding replaces the contention stall, so back-to-back write→read to the same word runs zero-wait.
- Adds a configurable read wait-state count and out-of-range/oversize detection with the two-cycle AHB ERROR response.
- Sits on an AHB3 interconnect slave port as on-chip instruction/data RAM.

Parameters:
- MEM_DEPTH, 256, number of XLEN-bit words; power of two, ≥2.
- PLEN, 32, HADDR width.
- XLEN, 32, data width; one of 8/16/32/64/128.
- READ_WAIT, 0, extra wait states inserted in every read data phase; 0..7.
- ERROR_ON_OOR, 1, 1 = ERROR response for out-of-range or oversize access; 0 = address wraps modulo memory size, always OKAY.
- TECHNOLOGY, "GENERIC", passed to the RAM macro.

Ports:
- HRESETn in 1: asynchronous reset, active-low.
- HCLK in 1: clock; all state updates on its rising edge.
- HSEL in 1: slave select.
- HADDR in PLEN: byte address.
- HWDATA in XLEN: write data, valid in data phase.
- HRDATA out XLEN: read data.
- HWRITE in 1: 1 = write.
- HSIZE in 3: transfer size.
- HBURST in 3: burst type; ignored (each beat is handled independently).
- HPROT in 4: protection; ignored.
- HTRANS in 2: IDLE/BUSY/NONSEQ/SEQ.
- HMASTLOCK in 1: ignored.
- HREADYOUT out 1: slave ready.
- HREADY in 1: bus ready.
- HRESP out 1: 0 = OKAY, 1 = ERROR.

Behaviour:
- Accept: HSEL & HREADY & HTRANS∈{NONSEQ,SEQ}. Any other HTRANS, or HSEL low, gives a zero-wait OKAY data phase with no state change.
- Word index: HADDR[LSB +: ABITS], where LSB = log2(XLEN/8) and ABITS = log2(MEM_DEPTH).
- Byte enables: from HSIZE and HADDR[LSB-1:0]; lanes = 2^HSIZE bytes shifted by the byte offset.
- Fault (ERROR_ON_OOR=1) when either holds:
  - HADDR ≥ MEM_DEPTH*XLEN/8, or
  - 2^HSIZE > XLEN/8.
- States:
  - IDLE: no active data phase.
  - WR: write data phase.
  - RD: read data phase.
  - RDWAIT: read wait states, counter of width log2(READ_WAIT+1).
  - ERR1, ERR2: first and second cycles of the ERROR response.
- Transitions:
  - Accepted write → WR.
  - Accepted read → RD if READ_WAIT=0, else RDWAIT with count = READ_WAIT.
  - Accepted fault → ERR1.
  - RDWAIT decrements each cycle; at 1 → RD.
  - ERR1 → ERR2.
  - WR, RD, ERR2 → re-evaluate the new address phase in the same cycle (pipelined).
- Outputs per state:
  - WR: HREADYOUT=1, HRESP=0. HWDATA is written with the registered byte enables in that cycle; zero wait.
  - RD: HREADYOUT=1, HRESP=0, HRDATA valid.
  - RDWAIT: HREADYOUT=0, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - A faulting write never modifies memory.
- Memory read is issued at address-phase acceptance (synchronous RAM, 1-cycle latency). For READ_WAIT>0 the RAM output is captured into a holding register and stays stable until RD.
- Forwarding: if a read is accepted while the state is WR and the word index equals the pending write index:
  - Register HWDATA and the write byte enables as fwd_data/fwd_be.
  - In the read data phase, HRDATA = per byte fwd_be ? fwd_data : ram_dout.
  - No stall, regardless of whether all bytes were written.
- HRDATA holds its last value outside RD.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, counter 0, fwd_be=0, pending write cleared.
- Reset mid-transfer aborts the transfer; a write in its data phase is not committed. Memory contents are not cleared.
- ERROR_ON_OOR=0: index wraps, HSIZE is clamped to XLEN, HRESP is always 0.

Decomposition:
- Shared package peripheral_ahb3_verilog_pkg:
  - Already holds HTRANS_*, HSIZE_*, HRESP_* constants.
  - Add typedef enum sram_state_t {IDLE, WR, RD, RDWAIT, ERR1, ERR2}.
- Put the byte-enable generator in the package as a function.
- One sub-module: the existing mpsoc_ram_1r1w (ABITS, DBITS, TECHNOLOGY), with separate write and read ports.

Test Plan:
- Write 0xDEADBEEF to word @0x10, then read @0x10 → HRDATA=0xDEADBEEF, HREADYOUT=1 in both data phases, HRESP=0.
- Pre-load 0x11223344 @0x20; byte write 0xAA to @0x21 immediately followed by read @0x20 → HRDATA=0x1122AA44, zero wait states.
- READ_WAIT=2: read @0x4 → HREADYOUT low exactly 2 cycles, then high with correct data; HRDATA stable throughout.
- MEM_DEPTH=256, XLEN=32: write @0x400 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). A following read @0x0 returns the unchanged value.
- HSIZE=DWORD on XLEN=32 → two-cycle ERROR. Same access with ERROR_ON_OOR=0 → OKAY; @0x400 aliases @0x0.
- Assert HRESETn low during WR of 0x55 @0x8 → outputs go to reset values immediately; a later read @0x8 returns the prior contents.
